biss_sniffer_core: RTL and testbench
====================================

// Module: biss_sniffer_core
// PURPOSE
// - Passive BiSS-C listener: watches MA clock (ssi_sck_i) and SLO data (ssi_dat_i) between an external master and an encoder.
// - Decodes each single-cycle frame, checks CRC6, publishes a sign-extended 32-bit position to the position bus.
// - Reports link status and frame errors; never drives the BiSS lines.
// PARAMETERS
// - IDLE_CYCLES   125  clk_i cycles of sck high that end or abort a frame (1 us @ 125 MHz)
// PORTS
// - clk_i      in   1   system clock; all logic on rising edge; one clock domain
// - reset_i    in   1   synchronous, active-high reset
// - BITS       in   8   position width in bits; legal 1..32
// - ssi_sck_i  in   1   BiSS MA clock, asynchronous, idles high
// - ssi_dat_i  in   1   BiSS SLO data, asynchronous, idles high
// - link_up_o  out  1   1 = last completed frame passed CRC
// - error_o    out  1   1 = last frame failed CRC or was aborted
// - posn_o     out  32  last valid position, sign-extended from BITS
// BEHAVIOUR
// - Reset: posn_o=0, link_up_o=0, error_o=0, FSM=IDLE, counters and CRC cleared.
// - Inputs pass through 2-FF synchronisers. A sample is the synchronised dat on a synchronised sck rising edge.
// - FSM states and transitions:
//   - IDLE: wait for sck falling edge -> ACK.
//   - ACK: wait for sample=0 -> START.
//   - START: wait for sample=1 -> CDS.
//   - CDS: discard one sample -> DATA.
//   - DATA: shift BITS samples, MSB first -> STAT.
//   - STAT: 2 samples nE,nW, active-low, not errors -> CRC.
//   - CRC: 6 samples -> DONE.
//   - DONE: single-cycle update -> IDLE.
// - CRC6: poly x^6+x+1 (0x43), init 0, serial over DATA and STAT bits; received CRC is transmitted inverted, MSB first.
// - DONE with CRC match:
//   - posn_o = data sign-extended from bit BITS-1 to 32 bits.
//   - link_up_o=1, error_o=0.
// - DONE with CRC mismatch: posn_o holds, link_up_o=0, error_o=1.
// - Abort: sck high for IDLE_CYCLES consecutive cycles in any state other than IDLE/DONE -> IDLE, error_o=1, link_up_o=0, posn_o holds.
// - Timeout in IDLE is normal inter-frame gap; no effect.
// - Latency: outputs update on the 4th clk_i rising edge after the final CRC bit's sck rising edge at the pins (2 sync + 1 edge detect + 1 register).
// - BITS is sampled at the START->CDS transition and held for the whole frame. BITS=0 behaves as 1; BITS>32 behaves as 32.
// - reset_i mid-frame: immediate return to reset state; the partial frame is discarded.
// - Outputs hold between frames. No timeout-based link drop beyond the abort rule.
// CONFIGURATION
// - BISS_SNIFFER_STATUS_EN defined:
//   - adds outputs nEnW_o[1:0] (raw nE,nW) and crc_o[5:0] (received CRC, de-inverted).
//   - both update in DONE regardless of CRC result; reset to 0.
// - BISS_SNIFFER_STATUS_EN undefined: these ports and their registers do not exist; all other behaviour is identical.
// STRUCTURE
// - Package biss_pkg:
//   - state enum (IDLE, ACK, START, CDS, DATA, STAT, CRC, DONE).
//   - CRC6_POLY=6'h03 (x^6 implicit), CRC_LEN=6, STAT_LEN=2, POSN_W=32.
// - Sub-module biss_crc6: serial CRC; ports clk_i, reset_i, clear, en, bit_i, crc_o[5:0].
// - Top holds synchronisers, edge detect, FSM, bit counter, shift register and output registers.
// TESTING
// - Clock 125 MHz, MA 2.5 MHz, BITS=32, frame data 0x12345678, nE=nW=1, correct CRC
//   -> posn_o=0x12345678, link_up_o=1, error_o=0.
// - BITS=18, data 0x20001 (bit 17 set), correct CRC
//   -> posn_o=0xFFFE0001; then data 0x00005 -> posn_o=0x00000005.
// - Valid frame (posn_o=0x12345678), then data 0xCAFEF00D with one CRC bit flipped
//   -> posn_o stays 0x12345678, error_o=1, link_up_o=0; next good frame restores link_up_o=1, error_o=0.
// - Frame stopped after 10 data bits, sck held high for 125+ cycles
//   -> error_o=1, link_up_o=0, posn_o unchanged; following full frame decodes correctly.
// - Back-to-back frames 0x00000001 then 0xFFFFFFFF, gap 2 us -> posn_o follows each value.
//   - With BISS_SNIFFER_STATUS_EN: frame with nE=0, nW=1 -> nEnW_o=2'b01, crc_o = transmitted CRC inverted.
// - reset_i asserted for 1 cycle mid-DATA -> all outputs 0; the next complete frame decodes correctly.

Source files
------------

// File: rtl/biss_pkg.sv
// Shared types, constants and helpers for the BiSS-C sniffer.
package biss_pkg;

    localparam int unsigned POSN_W   = 32;
    localparam int unsigned CRC_LEN  = 6;
    localparam int unsigned STAT_LEN = 2;
    localparam int unsigned CNT_W    = 6;
    localparam int unsigned IDX_W    = $clog2(POSN_W);

    // x^6 term is implicit in the shift-out of the register MSB
    localparam logic [CRC_LEN-1:0] CRC6_POLY = 6'h03;

    typedef enum logic [2:0] {
        IDLE,
        ACK,
        START,
        CDS,
        DATA,
        STAT,
        CRC,
        DONE
    } state_e;

    // Map the requested position width onto the supported 1..POSN_W range
    function automatic logic [CNT_W-1:0] clamp_bits(input logic [7:0] bits);
        if (bits == 8'd0) return CNT_W'(1);
        if (bits > 8'(POSN_W)) return CNT_W'(POSN_W);
        return CNT_W'(bits);
    endfunction

    function automatic logic [POSN_W-1:0] sign_ext(input logic [POSN_W-1:0] data,
                                                   input logic [CNT_W-1:0]  nbits);
        logic [POSN_W-1:0] upper;
        upper = {POSN_W{1'b1}} << nbits;
        return data[IDX_W'(nbits - CNT_W'(1))] ? (data | upper) : (data & ~upper);
    endfunction

endpackage

// File: rtl/biss_crc6.sv
// Serial CRC6 (x^6+x+1), MSB-first, zero initial value.
module biss_crc6
    import biss_pkg::*;
(
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear,
    input  logic               en,
    input  logic               bit_i,
    output logic [CRC_LEN-1:0] crc_o
);

    logic fb;

    assign fb = bit_i ^ crc_o[CRC_LEN-1];

    always_ff @(posedge clk_i) begin
        if (reset_i || clear) begin
            crc_o <= '0;
        end else if (en) begin
            crc_o <= {crc_o[CRC_LEN-2:0], 1'b0} ^ ({CRC_LEN{fb}} & CRC6_POLY);
        end
    end

endmodule

// File: rtl/biss_sniffer_core.sv
// Passive BiSS-C frame decoder: syncs MA/SLO, decodes one frame, checks CRC6, publishes position.
// Define BISS_SNIFFER_STATUS_EN to expose the raw nE/nW bits and the received CRC.
module biss_sniffer_core
    import biss_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = 125
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [7:0]        BITS,
    input  logic              ssi_sck_i,
    input  logic              ssi_dat_i,
    output logic              link_up_o,
    output logic              error_o,
    output logic [POSN_W-1:0] posn_o
`ifdef BISS_SNIFFER_STATUS_EN
    ,
    output logic [STAT_LEN-1:0] nEnW_o,
    output logic [CRC_LEN-1:0]  crc_o
`endif
);

    localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);

    logic [1:0]         sck_sync;
    logic [1:0]         dat_sync;
    logic               sck_prev;
    logic               sck_rise;
    logic               sck_fall;
    logic               sample;
    logic [IDLE_W-1:0]  idle_cnt;
    logic               timeout;
    state_e             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   bits_lat;
    logic [POSN_W-1:0]  data_sr;
    logic [CRC_LEN-1:0] crc_rx;
    logic [CRC_LEN-1:0] crc_calc;
    logic               crc_clear;
    logic               crc_en;
`ifdef BISS_SNIFFER_STATUS_EN
    logic [STAT_LEN-1:0] stat_sr;
`endif

    // Both lines idle high, so the synchronisers reset high to avoid a false edge
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sck_sync <= 2'b11;
            dat_sync <= 2'b11;
            sck_prev <= 1'b1;
        end else begin
            sck_sync <= {sck_sync[0], ssi_sck_i};
            dat_sync <= {dat_sync[0], ssi_dat_i};
            sck_prev <= sck_sync[1];
        end
    end

    assign sck_rise = sck_sync[1] & ~sck_prev;
    assign sck_fall = ~sck_sync[1] & sck_prev;
    assign sample   = dat_sync[1];

    always_ff @(posedge clk_i) begin
        if (reset_i || !sck_sync[1]) begin
            idle_cnt <= '0;
        end else if (!timeout) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    assign timeout = (idle_cnt == IDLE_W'(IDLE_CYCLES));

    assign crc_clear = (state == START) && sck_rise && sample;
    assign crc_en    = sck_rise && ((state == DATA) || (state == STAT));

    biss_crc6 u_crc (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear   (crc_clear),
        .en      (crc_en),
        .bit_i   (sample),
        .crc_o   (crc_calc)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bits_lat  <= CNT_W'(1);
            data_sr   <= '0;
            crc_rx    <= '0;
            posn_o    <= '0;
            link_up_o <= 1'b0;
            error_o   <= 1'b0;
`ifdef BISS_SNIFFER_STATUS_EN
            stat_sr   <= '0;
            nEnW_o    <= '0;
            crc_o     <= '0;
`endif
        end else if (timeout && (state != IDLE) && (state != DONE)) begin
            // Master stopped clocking mid-frame
            state     <= IDLE;
            link_up_o <= 1'b0;
            error_o   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (sck_fall) state <= ACK;
                end
                ACK: begin
                    if (sck_rise && !sample) state <= START;
                end
                START: begin
                    if (sck_rise && sample) begin
                        state    <= CDS;
                        bits_lat <= clamp_bits(BITS);
                        bit_cnt  <= '0;
                        data_sr  <= '0;
                    end
                end
                CDS: begin
                    if (sck_rise) state <= DATA;
                end
                DATA: begin
                    if (sck_rise) begin
                        data_sr <= {data_sr[POSN_W-2:0], sample};
                        if (bit_cnt == bits_lat - CNT_W'(1)) begin
                            bit_cnt <= '0;
                            state   <= STAT;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                STAT: begin
                    if (sck_rise) begin
`ifdef BISS_SNIFFER_STATUS_EN
                        stat_sr <= {stat_sr[0], sample};
`endif
                        if (bit_cnt == CNT_W'(STAT_LEN - 1)) begin
                            bit_cnt <= '0;
                            state   <= CRC;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                CRC: begin
                    if (sck_rise) begin
                        // Slave sends the CRC inverted; store it in true polarity
                        crc_rx <= {crc_rx[CRC_LEN-2:0], ~sample};
                        if (bit_cnt == CNT_W'(CRC_LEN - 1)) begin
                            bit_cnt <= '0;
                            state   <= DONE;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (crc_rx == crc_calc) begin
                        posn_o    <= sign_ext(data_sr, bits_lat);
                        link_up_o <= 1'b1;
                        error_o   <= 1'b0;
                    end else begin
                        link_up_o <= 1'b0;
                        error_o   <= 1'b1;
                    end
`ifdef BISS_SNIFFER_STATUS_EN
                    nEnW_o <= stat_sr;
                    crc_o  <= crc_rx;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_biss_sniffer_core.sv
// Bench for biss_sniffer_core: directed spec frames plus randomized frames against a CRC/sign-extension model.
module tb_biss_sniffer_core;

    localparam int HALF_SLOW = 25;
    localparam int HALF_FAST = 5;
    localparam int GAP       = 250;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [7:0]  BITS;
    logic        ssi_sck_i;
    logic        ssi_dat_i;
    logic        link_up_o;
    logic        error_o;
    logic [31:0] posn_o;
`ifdef BISS_SNIFFER_STATUS_EN
    logic [1:0]  nEnW_o;
    logic [5:0]  crc_o;
`endif

    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [31:0] exp_posn;
    logic        exp_link;
    logic        exp_err;
    logic [1:0]  exp_nenw;
    logic [5:0]  exp_crc;

    always #4 clk_i = ~clk_i;

    biss_sniffer_core dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .BITS      (BITS),
        .ssi_sck_i (ssi_sck_i),
        .ssi_dat_i (ssi_dat_i),
        .link_up_o (link_up_o),
        .error_o   (error_o),
        .posn_o    (posn_o)
`ifdef BISS_SNIFFER_STATUS_EN
        ,
        .nEnW_o    (nEnW_o),
        .crc_o     (crc_o)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_posn"}, posn_o, exp_posn);
        check_eq({tag, "_link"}, 32'(link_up_o), 32'(exp_link));
        check_eq({tag, "_err"}, 32'(error_o), 32'(exp_err));
`ifdef BISS_SNIFFER_STATUS_EN
        check_eq({tag, "_nenw"}, 32'(nEnW_o), 32'(exp_nenw));
        check_eq({tag, "_crc"}, 32'(crc_o), 32'(exp_crc));
`endif
    endtask

    function automatic int eff_bits(input logic [7:0] b);
        if (b == 8'd0) return 1;
        if (b > 8'd32) return 32;
        return int'(b);
    endfunction

    // Remainder of M(x)*x^6 divided by x^6+x+1, computed by long division
    function automatic logic [5:0] crc6_ref(input logic [31:0] d, input int n, input bit ne, input bit nw);
        logic [63:0] v;
        v = ((64'(d) << 2) | (64'(ne) << 1) | 64'(nw)) << 6;
        for (int i = n + 7; i >= 6; i--) begin
            if (v[i]) v = v ^ (64'h43 << (i - 6));
        end
        return v[5:0];
    endfunction

    function automatic logic [31:0] sext_ref(input logic [31:0] d, input int n);
        longint v;
        v = longint'({32'd0, d});
        if (v >= (longint'(1) << (n - 1))) v = v - (longint'(1) << n);
        return 32'(v);
    endfunction

    // One MA clock period: fall with data presented, then rise (slave data sampled)
    task automatic ma_bit(input bit b, input int half, input bit last);
        ssi_dat_i = b;
        ssi_sck_i = 1'b0;
        repeat (half) @(negedge clk_i);
        ssi_sck_i = 1'b1;
        if (!last) repeat (half) @(negedge clk_i);
    endtask

    task automatic send_frame(input string name, input logic [31:0] data, input logic [7:0] nbits,
                              input bit ne, input bit nw, input bit bad, input int flip,
                              input int cut, input bit rst_mid, input int half, input int nbits_mid);
        int          n;
        int          stop;
        logic [31:0] d;
        logic [5:0]  crc;
        logic [5:0]  crc_tx;
        bit          q[$];
        n = eff_bits(nbits);
        d = (n == 32) ? data : (data & ((32'd1 << n) - 32'd1));
        crc = crc6_ref(d, n, ne, nw);
        crc_tx = ~crc;
        if (bad) crc_tx[flip] = ~crc_tx[flip];
        q.push_back(1'b1);
        q.push_back(1'b0);
        q.push_back(1'b1);
        q.push_back(1'b0);
        for (int i = n - 1; i >= 0; i--) q.push_back(d[i]);
        q.push_back(ne);
        q.push_back(nw);
        for (int i = 5; i >= 0; i--) q.push_back(crc_tx[i]);
        stop = (cut > 0 && cut < q.size()) ? cut : q.size();

        BITS = nbits;
        for (int i = 0; i < stop; i++) begin
            if (i == 4 && nbits_mid >= 0) BITS = 8'(nbits_mid);
            ma_bit(q[i], half, i == stop - 1);
        end

        if (rst_mid) begin
            repeat (2) @(negedge clk_i);
            reset_i = 1'b1;
            @(negedge clk_i);
            reset_i = 1'b0;
            exp_posn = '0;
            exp_link = 1'b0;
            exp_err  = 1'b0;
            exp_nenw = '0;
            exp_crc  = '0;
            @(posedge clk_i);
            #1;
            check_outputs({name, "_rst"});
            @(negedge clk_i);
            for (int i = stop; i < q.size(); i++) ma_bit(q[i], half, 1'b0);
            ssi_dat_i = 1'b1;
            repeat (GAP) @(negedge clk_i);
            // The leftover tail cannot form a whole frame, so it ends as an abort
            exp_link = 1'b0;
            exp_err  = 1'b1;
            @(posedge clk_i);
            #1;
            check_outputs({name, "_tail"});
            @(negedge clk_i);
        end else if (stop < q.size()) begin
            @(negedge clk_i);
            ssi_dat_i = 1'b1;
            repeat (GAP) @(negedge clk_i);
            exp_link = 1'b0;
            exp_err  = 1'b1;
            @(posedge clk_i);
            #1;
            check_outputs({name, "_abort"});
            @(negedge clk_i);
        end else begin
            repeat (3) @(posedge clk_i);
            #1;
            check_outputs({name, "_pre"});
            if (!bad) begin
                exp_posn = sext_ref(d, n);
                exp_link = 1'b1;
                exp_err  = 1'b0;
            end else begin
                exp_link = 1'b0;
                exp_err  = 1'b1;
            end
            exp_nenw = {ne, nw};
            exp_crc  = ~crc_tx;
            @(posedge clk_i);
            #1;
            check_outputs({name, "_post"});
            @(negedge clk_i);
            ssi_dat_i = 1'b1;
            repeat (GAP) @(negedge clk_i);
        end
    endtask

    initial begin
        #(8 * 150000);
        $display("FAIL watchdog: cycle budget exhausted");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] nb;
        int         cut;
        int         mid;
        reset_i   = 1'b1;
        BITS      = 8'd32;
        ssi_sck_i = 1'b1;
        ssi_dat_i = 1'b1;
        exp_posn  = '0;
        exp_link  = 1'b0;
        exp_err   = 1'b0;
        exp_nenw  = '0;
        exp_crc   = '0;
        repeat (4) @(negedge clk_i);
        check_outputs("reset");
        reset_i = 1'b0;
        repeat (GAP) @(negedge clk_i);

        send_frame("f32", 32'h12345678, 8'd32, 1, 1, 0, 0, 0, 0, HALF_SLOW, -1);
        check_eq("spec_f32", posn_o, 32'h12345678);
        send_frame("b18a", 32'h00020001, 8'd18, 1, 1, 0, 0, 0, 0, HALF_SLOW, -1);
        check_eq("spec_b18a", posn_o, 32'hFFFE0001);
        send_frame("b18b", 32'h00000005, 8'd18, 1, 1, 0, 0, 0, 0, HALF_SLOW, -1);
        check_eq("spec_b18b", posn_o, 32'h00000005);

        send_frame("good", 32'h12345678, 8'd32, 1, 1, 0, 0, 0, 0, HALF_SLOW, -1);
        send_frame("badcrc", 32'hCAFEF00D, 8'd32, 1, 1, 1, 2, 0, 0, HALF_SLOW, -1);
        check_eq("spec_badcrc_posn", posn_o, 32'h12345678);
        check_eq("spec_badcrc_err", 32'(error_o), 32'd1);
        send_frame("good2", 32'h0BADBEEF, 8'd32, 1, 1, 0, 0, 0, 0, HALF_SLOW, -1);

        send_frame("abort", 32'hA5A5A5A5, 8'd32, 1, 1, 0, 0, 14, 0, HALF_SLOW, -1);
        check_eq("spec_abort_posn", posn_o, 32'h0BADBEEF);
        send_frame("after_abort", 32'h13572468, 8'd32, 1, 1, 0, 0, 0, 0, HALF_SLOW, -1);

        send_frame("b2b1", 32'h00000001, 8'd32, 1, 1, 0, 0, 0, 0, HALF_SLOW, -1);
        check_eq("spec_b2b1", posn_o, 32'h00000001);
        send_frame("b2b2", 32'hFFFFFFFF, 8'd32, 1, 1, 0, 0, 0, 0, HALF_SLOW, -1);
        check_eq("spec_b2b2", posn_o, 32'hFFFFFFFF);

        send_frame("nenw", 32'h00ABCDEF, 8'd32, 0, 1, 0, 0, 0, 0, HALF_SLOW, -1);
        send_frame("bits0", 32'h00000001, 8'd0, 1, 1, 0, 0, 0, 0, HALF_SLOW, -1);
        check_eq("spec_bits0", posn_o, 32'hFFFFFFFF);
        send_frame("bits40", 32'h80000000, 8'd40, 1, 1, 0, 0, 0, 0, HALF_SLOW, -1);
        check_eq("spec_bits40", posn_o, 32'h80000000);
        send_frame("bitsmid", 32'h000003FF, 8'd10, 1, 1, 0, 0, 0, 0, HALF_SLOW, 20);
        check_eq("spec_bitsmid", posn_o, 32'hFFFFFFFF);

        send_frame("rst", 32'h55AA55AA, 8'd32, 1, 1, 0, 0, 14, 1, HALF_SLOW, -1);
        send_frame("after_rst", 32'h600DF00D, 8'd32, 1, 1, 0, 0, 0, 0, HALF_SLOW, -1);
        check_eq("spec_after_rst", posn_o, 32'h600DF00D);

        for (int k = 0; k < 30; k++) begin
            nb  = 8'($urandom_range(0, 40));
            cut = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 40)) : 0;
            mid = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1;
            send_frame($sformatf("rnd%0d", k), $urandom, nb,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0), int'($urandom_range(0, 5)),
                       cut, 1'b0, HALF_FAST, mid);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
